// File: rtl/piso_tx.sv
// piso_tx
//    Parallel-in, serial-out transmitter. Accepts an NBITS word over a
//    valid/ready handshake and sends it one bit per enabled clock on 'so',
//    LSB first by default (MSB first when MSB_FIRST=1). A new word can be
//    accepted on the same edge that sends the last bit of the current one,
//    so back-to-back words leave no idle gap on the line.
//
// Parameters
//    NBITS      word width, 2..32
//    MSB_FIRST  0: bit 0 goes out first, 1: bit NBITS-1 goes out first
//
// Ports
//    clk    in   rising-edge clock
//    rst_n  in   synchronous active-low reset
//    en     in   clock enable / bit tick; state moves only when high
//    din    in   parallel word, captured on an accept edge
//    load   in   word valid
//    ready  out  transmitter can take 'din' on this edge
//    so     out  serial data
//    so_en  out  'so' carries a data bit
//    done   out  one-clock pulse in the cycle after the last bit
module piso_tx #(
   parameter int NBITS     = 4,
   parameter int MSB_FIRST = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [NBITS-1:0] din,
   input  logic             load,
   output logic             ready,
   output logic             so,
   output logic             so_en,
   output logic             done
);

   localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]       state;
   logic [NBITS-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic             done_q;
   logic             last_bit;
   logic             accept;

   // The last bit is on the line; this edge can both finish the word and
   // take the next one, which is what removes the gap between words.
   assign last_bit = (state == SHIFT) && (cnt == LAST);
   assign ready    = en && ((state == IDLE) || last_bit);
   assign accept   = load && ready;

   assign so    = (MSB_FIRST != 0) ? shreg[NBITS-1] : shreg[0];
   assign so_en = (state == SHIFT);
   assign done  = done_q;

   // Main sequencer. 'done' is rewritten on every non-reset edge so that it
   // drops after one clock even while 'en' is low; everything else only moves
   // on enabled edges. The register is cleared when a word ends so that 'so'
   // idles at 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         shreg  <= '0;
         cnt    <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= en && last_bit;
         if (en) begin
            if (accept) begin
               state <= SHIFT;
               shreg <= din;
               cnt   <= '0;
            end else if (state == SHIFT) begin
               if (cnt == LAST) begin
                  state <= IDLE;
                  shreg <= '0;
                  cnt   <= '0;
               end else begin
                  if (MSB_FIRST != 0) begin
                     shreg <= shreg << 1;
                  end else begin
                     shreg <= shreg >> 1;
                  end
                  cnt <= cnt + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx
//    Bench for piso_tx. Two instances share the stimulus: one sends LSB
//    first, the other MSB first. A bit-index reference model predicts the
//    line for both, a right shift register hangs off the LSB-first line, a
//    vector table covers the basic word / back-to-back / reset cases, and
//    hand-written sequences cover stalls, busy loads and mid-word reset
//    before a randomized run.
module tb_piso_tx;

   localparam int NB = 4;

   logic          clk;
   logic          rst_n;
   logic          en;
   logic [NB-1:0] din;
   logic          load;
   logic          ready0, so0, so_en0, done0;
   logic          ready1, so1, so_en1, done1;
   logic [NB-1:0] rsr;

   int total = 0;
   int bad   = 0;

   // reference model state: which word is going out and which bit index
   logic          m_valid = 1'b0;
   logic          m_active = 1'b0;
   int            m_pos = 0;
   logic [NB-1:0] m_word = '0;
   logic          m_done = 1'b0;
   logic [NB-1:0] m_done_word = '0;

   piso_tx #(.NBITS(NB), .MSB_FIRST(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .en(en), .din(din), .load(load),
      .ready(ready0), .so(so0), .so_en(so_en0), .done(done0)
   );

   piso_tx #(.NBITS(NB), .MSB_FIRST(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .din(din), .load(load),
      .ready(ready1), .so(so1), .so_en(so_en1), .done(done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // downstream right shift register, serial in at the top, clocked on the
   // same enabled edges as the transmitter
   always @(posedge clk) begin
      if (en) rsr <= {so0, rsr[NB-1:1]};
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic modelReady(input logic e);
      return e && (!m_active || (m_pos == NB - 1));
   endfunction

   function automatic logic expSo(input logic msb);
      if (!m_active) return 1'b0;
      return msb ? m_word[NB-1-m_pos] : m_word[m_pos];
   endfunction

   // One clock: drive inputs in the low phase, check ready, advance the model
   // at the edge, check the line in the following low phase.
   task automatic applyStimulus(input logic r, input logic e, input logic l, input logic [NB-1:0] d);
      logic rdy;
      rst_n = r; en = e; load = l; din = d;
      #1;
      rdy = modelReady(e);
      if (m_valid) begin
         checkOutput("ready_lsb", ready0, rdy);
         checkOutput("ready_msb", ready1, rdy);
      end
      @(posedge clk);
      if (!r) begin
         m_valid = 1'b1; m_active = 1'b0; m_pos = 0; m_done = 1'b0;
      end else begin
         m_done = e && m_active && (m_pos == NB - 1);
         if (m_done) m_done_word = m_word;
         if (e) begin
            if (l && rdy) begin
               m_active = 1'b1; m_word = d; m_pos = 0;
            end else if (m_active) begin
               if (m_pos == NB - 1) m_active = 1'b0;
               else m_pos++;
            end
         end
      end
      @(negedge clk);
      if (m_valid) begin
         checkOutput("so_lsb",    so0,    expSo(1'b0));
         checkOutput("so_msb",    so1,    expSo(1'b1));
         checkOutput("so_en_lsb", so_en0, m_active);
         checkOutput("so_en_msb", so_en1, m_active);
         checkOutput("done_lsb",  done0,  m_done);
         checkOutput("done_msb",  done1,  m_done);
         if (m_done) checkOutput("rsr_word", rsr, m_done_word);
      end
   endtask

   typedef struct {
      logic          r;
      logic          e;
      logic          l;
      logic [NB-1:0] d;
      logic          x_ready;
      logic          x_so;
      logic          x_so_en;
      logic          x_done;
   } vec_t;

   vec_t tbl[19];

   initial begin
      // single word 1011
      tbl[0]  = '{1'b1, 1'b1, 1'b1, 4'hB, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1};
      // back-to-back A then 5, load held through the second word
      tbl[5]  = '{1'b1, 1'b1, 1'b1, 4'hA, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[10] = '{1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[12] = '{1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[13] = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1};
      // reset held two edges during SHIFT, then load with reset low
      tbl[14] = '{1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[15] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[16] = '{1'b0, 1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[17] = '{1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[18] = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};

      rst_n = 1'b0; en = 1'b1; load = 1'b0; din = '0;
      applyStimulus(1'b0, 1'b1, 1'b0, 4'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 4'h0);
      checkOutput("reset_so",    so0,    1'b0);
      checkOutput("reset_so_en", so_en0, 1'b0);
      checkOutput("reset_done",  done0,  1'b0);

      for (int i = 0; i < 19; i++) begin
         rst_n = tbl[i].r; en = tbl[i].e;
         #1;
         checkOutput($sformatf("tbl%0d_ready", i), ready0, tbl[i].x_ready);
         applyStimulus(tbl[i].r, tbl[i].e, tbl[i].l, tbl[i].d);
         checkOutput($sformatf("tbl%0d_so", i),    so0,    tbl[i].x_so);
         checkOutput($sformatf("tbl%0d_so_en", i), so_en0, tbl[i].x_so_en);
         checkOutput($sformatf("tbl%0d_done", i),  done0,  tbl[i].x_done);
      end

      // enable stall: 4'h6, en low for three edges while bit 1 is out
      applyStimulus(1'b1, 1'b1, 1'b1, 4'h6);
      checkOutput("stall_b0", so0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'h0);
      checkOutput("stall_b1", so0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 4'hF);
         checkOutput("stall_hold", so0, 1'b1);
         checkOutput("stall_ready", ready0, 1'b0);
         checkOutput("stall_nodone", done0, 1'b0);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 4'h0);
      checkOutput("stall_b2", so0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'h0);
      checkOutput("stall_b3", so0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'h0);
      checkOutput("stall_done", done0, 1'b1);
      checkOutput("stall_rsr", rsr, 4'h6);

      // MSB first 1000, loads while busy must not disturb the word
      applyStimulus(1'b1, 1'b1, 1'b1, 4'h8);
      checkOutput("msb_b0", so1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1, 4'hF);
      checkOutput("msb_b1", so1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 4'hF);
      checkOutput("msb_b2", so1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'h0);
      checkOutput("msb_b3", so1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'h0);
      checkOutput("msb_done", done1, 1'b1);

      // reset in cycle 2 of a word, then a fresh word
      applyStimulus(1'b1, 1'b1, 1'b1, 4'h9);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 4'h0);
      checkOutput("midrst_so_en", so_en0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'h0);
      checkOutput("midrst_nodone", done0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 4'h3);
      for (int k = 0; k < NB; k++) applyStimulus(1'b1, 1'b1, 1'b0, 4'h0);
      checkOutput("midrst_rsr", rsr, 4'h3);

      // randomized traffic against the model
      for (int k = 0; k < 400; k++) begin
         applyStimulus(($urandom_range(0, 39) != 0),
                       ($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 1)),
                       NB'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
